serial_subtractor_32bit: RTL
============================

# serial_subtractor_32bit

Digit-serial two's-complement subtractor computing A − B − bin over a WIDTH-bit word, DIGIT bits per clock. It is the subtraction counterpart to the ripple-carry adder family: a small-area, multi-cycle datapath behind a valid/ready handshake. It is the sequential inverse-operation entry in the adder architecture comparison.

## Interface
- WIDTH, 32, operand/result width; must be a multiple of DIGIT.
- DIGIT, 4, bits processed per cycle; N = WIDTH/DIGIT cycles per operation, with N ≥ 1.

- clk_i  input  1  clock, rising edge.
- rst_ni  input  1  reset: synchronous, active-low. One clock, sampled on clk_i rising edge.
- valid_i  input  1  operands valid.
- ready_o  output  1  block can accept operands.
- A_i  input  WIDTH  minuend.
- B_i  input  WIDTH  subtrahend.
- bin_i  input  1  borrow in.
- valid_o  output  1  result valid.
- ready_i  input  1  consumer accepts result.
- DIFF_o  output  WIDTH  A_i − B_i − bin_i, modulo 2^WIDTH.
- bout_o  output  1  borrow out: 1 iff the unsigned value A < B + bin.
- ovf_o  output  1  signed overflow.

## Operation
- Arithmetic: DIFF = A + ~B + ~bin. The internal carry register is initialised to ~bin_i. bout_o = ~(final carry).
- ovf_o = (A[MSB] != B[MSB]) && (DIFF[MSB] != A[MSB]). It is evaluated on the latched A/B MSBs.
- FSM states:
  - IDLE: ready_o=1, valid_o=0.
    - On valid_i && ready_o: latch A_i, ~B_i and carry=~bin_i, clear the digit counter, then go to BUSY.
    - valid_i without ready_o is never accepted.
  - BUSY: ready_o=0.
    - Each cycle, add digit k (LSB digit first) of A and ~B with the carry.
    - Shift the DIGIT sum bits into the result register from the MSB end.
    - Update the carry and increment the counter.
    - After digit N−1 is processed, go to DONE.
  - DONE: valid_o=1, ready_o=0.
    - DIFF_o, bout_o and ovf_o are held stable.
    - On ready_i, go to IDLE.
- Inputs A_i, B_i and bin_i are don't-care outside the accepting cycle. Changes during BUSY have no effect.
- There is no overlap of operations: a new accept is possible only in IDLE.

## Timing
- Reset: rst_ni low at a rising edge forces, on that edge:
  - state IDLE; counter, carry, result, bout_o, ovf_o all 0.
  - ready_o=1 and valid_o=0 from the following cycle.
- Reset in any state, including mid-BUSY and DONE, discards the operation. No valid_o is produced for it.
- Latency: operands accepted at edge E0. BUSY spans edges E1..EN. valid_o is high in the cycle after EN, i.e. N cycles after the accept edge (8 for the defaults).
- DIFF_o, bout_o and ovf_o are registered. They are valid whenever valid_o=1 and keep their last value in IDLE until the next completion.
- Handshake: a result transfer is the edge where valid_o && ready_i. The FSM is in IDLE after that edge, so the earliest next accept is at the following edge.
  - Minimum period per operation: N+2 cycles.
- ready_i high before DONE has no effect. ready_i low holds DONE indefinitely.
- valid_i asserted in BUSY or DONE is ignored; the upstream must hold it until ready_o.
- N=1 (DIGIT=WIDTH): BUSY lasts one cycle. The counter must still be at least 1 bit wide.

## Test plan
- Reset:
  - Hold rst_ni=0 for 2 cycles, with valid_i=1 held.
  - Required: ready_o=1, valid_o=0, DIFF_o=0, bout_o=0, ovf_o=0.
  - Required: no operation is accepted while rst_ni=0.
- Basic subtraction:
  - A=0x0000_0005, B=0x0000_0003, bin=0.
  - Required: valid_o rises exactly 8 cycles after the accept edge.
  - Required: DIFF_o=0x0000_0002, bout_o=0, ovf_o=0.
- Borrow cases:
  - A=0x0, B=0x1, bin=0 → DIFF_o=0xFFFF_FFFF, bout_o=1, ovf_o=0.
  - A=B=0x1234_5678, bin=1 → DIFF_o=0xFFFF_FFFF, bout_o=1.
- Signed overflow:
  - A=0x8000_0000, B=0x0000_0001 → DIFF_o=0x7FFF_FFFF, bout_o=0, ovf_o=1.
  - A=0x7FFF_FFFF, B=0xFFFF_FFFF → DIFF_o=0x8000_0000, bout_o=1, ovf_o=1.
- Backpressure and operand stability:
  - Hold ready_i=0 for 5 cycles in DONE, while toggling A_i/B_i and pulsing valid_i.
  - Required: outputs stable, ready_o=0 throughout.
  - Then ready_i=1 for one cycle → IDLE (ready_o=1) next cycle, and the next operation accepts and computes correctly.
- Reset mid-operation:
  - Assert rst_ni=0 at the 4th BUSY cycle.
  - Required: IDLE with all outputs 0, and no valid_o for the aborted operation.
  - Required: a subsequent op A=0xFFFF_FFFF, B=0xFFFF_FFFE, bin=0 gives DIFF_o=0x1, bout_o=0, ovf_o=0.

Source files
------------

// File: rtl/serial_subtractor_32bit.sv
// serial_subtractor_32bit
// Digit-serial two's-complement subtractor: DIFF = A - B - bin, computed as
// A + ~B + ~bin, DIGIT bits per clock behind a valid/ready handshake.
// The DIFF, borrow-out and overflow outputs are separate registers. They update
// only when an operation completes, so they stay stable while the next
// operation is in progress.

module serial_subtractor_32bit #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] A_i,
    input  logic [WIDTH-1:0] B_i,
    input  logic             bin_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] DIFF_o,
    output logic             bout_o,
    output logic             ovf_o
);

    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] a_q, a_d;          // minuend, shifted right one digit per cycle
    logic [WIDTH-1:0] nb_q, nb_d;        // inverted subtrahend, shifted likewise
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sh_q, sh_d;        // partial result, filled from the MSB end
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;
    logic [DIGIT:0]   sum;

    // One digit of A + ~B + carry; the top bit is the carry out of the digit.
    function automatic logic [DIGIT:0] digit_add(input logic [DIGIT-1:0] a,
                                                 input logic [DIGIT-1:0] b,
                                                 input logic             c);
        return {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, c};
    endfunction

    // State register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (valid_i)        state_d = BUSY;
            BUSY:    if (cnt_q == LAST)  state_d = DONE;
            DONE:    if (ready_i)        state_d = IDLE;
            default:                     state_d = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state.
    always_comb begin
        ready_o = (state_q == IDLE);
        valid_o = (state_q == DONE);
    end

    // Datapath next-state: latch operands on accept, add one digit per BUSY cycle.
    always_comb begin
        sum     = digit_add(a_q[DIGIT-1:0], nb_q[DIGIT-1:0], carry_q);
        a_d     = a_q;
        nb_d    = nb_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    a_d     = A_i;
                    nb_d    = ~B_i;
                    carry_d = ~bin_i;
                    cnt_d   = '0;
                    a_msb_d = A_i[WIDTH-1];
                    b_msb_d = B_i[WIDTH-1];
                end
            end
            BUSY: begin
                a_d     = a_q >> DIGIT;
                nb_d    = nb_q >> DIGIT;
                carry_d = sum[DIGIT];
                cnt_d   = cnt_q + CNT_W'(1);
                sh_d    = WIDTH'({sum[DIGIT-1:0], sh_q} >> DIGIT);
                if (cnt_q == LAST) begin
                    // The last digit carries the result MSB.
                    diff_d = sh_d;
                    bout_d = ~sum[DIGIT];
                    ovf_d  = (a_msb_q != b_msb_q) && (sum[DIGIT-1] != a_msb_q);
                end
            end
            default: ;
        endcase
    end

    // Datapath registers; reset clears everything so an aborted op leaves no trace.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            a_q     <= '0;
            nb_q    <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sh_q    <= '0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            a_q     <= a_d;
            nb_q    <= nb_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign DIFF_o = diff_q;
    assign bout_o = bout_q;
    assign ovf_o  = ovf_q;

endmodule
